demux_burst_scheduler: RTL

//  Sequences a shared 1-to-4 demux: accepts a single valid/ready input stream and

---
 rtl/demux_sched_pkg.sv | 32 +++
 rtl/demux_burst_scheduler_if.sv | 21 ++
 rtl/demux_route_1x4.sv | 22 ++
 rtl/demux_burst_scheduler.sv | 98 +++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the burst-scheduling 1-to-4 demux.
package demux_sched_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Round-robin: first enabled channel after 'last', wrapping back to 'last' itself.
  function automatic logic [SELW-1:0] rr_pick(input logic [NCH-1:0] mask,
                                              input logic [SELW-1:0] last);
    logic [SELW-1:0] pick;
    logic [SELW-1:0] cand;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = last + SELW'(i);
      if (!found && mask[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux_burst_scheduler_if.sv
// Stream-in / four-channel-out bundle of the burst scheduler.
interface demux_burst_scheduler_if #(parameter int DW = 8);
  import demux_sched_pkg::*;

  logic                en;
  logic [NCH-1:0]      chan_mask;
  logic                in_valid;
  logic [DW-1:0]       in_data;
  logic                in_ready;
  logic [NCH-1:0]      out_valid;
  logic [NCH*DW-1:0]   out_data;
  logic [NCH-1:0]      out_ready;
  logic [SELW-1:0]     sel;
  logic                busy;

  // master: the scheduler itself; slave: source/consumer environment.
  modport master (input  en, chan_mask, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, sel, busy);
  modport slave  (output en, chan_mask, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, sel, busy);
endinterface

// File: rtl/demux_route_1x4.sv
// Combinational 1-to-4 route of the hold stage onto the selected channel.
module demux_route_1x4
  import demux_sched_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              valid,
  input  logic [DW-1:0]     data,
  input  logic [SELW-1:0]   sel,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH*DW-1:0] out_data
);

  // Data is always steered to the selected slice; only valid is qualified.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    out_valid[sel] = valid;
    out_data[int'(sel)*DW +: DW] = data;
  end

endmodule

// File: rtl/demux_burst_scheduler.sv
// Round-robin burst dispatcher of one stream onto four channels via a hold register.
module demux_burst_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input logic                     clk,
  input logic                     rst,
  demux_burst_scheduler_if.master bus
);

  localparam int CW = $clog2(BURST + 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_valid_q, hold_valid_d;
  logic [DW-1:0]   hold_data_q, hold_data_d;
  logic            fire, accept, in_ready;

  always_comb begin
    fire     = hold_valid_q && bus.out_ready[sel_q];
    in_ready = bus.en && (state_q == XFER) && (!hold_valid_q || bus.out_ready[sel_q]);
    accept   = bus.in_valid && in_ready;

    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;

    // A simultaneous fire and accept leaves the hold full with the new beat.
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = bus.in_data;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: if (bus.en && bus.chan_mask != '0) state_d = ARB;
      ARB: begin
        if (!bus.en || bus.chan_mask == '0) begin
          state_d = IDLE;
        end else begin
          sel_d   = rr_pick(bus.chan_mask, last_q);
          last_d  = sel_d;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BURST - 1)) state_d = DRAIN;
        end else if (!bus.en) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (!hold_valid_q || fire) state_d = bus.en ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_q       <= '1;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.sel      = sel_q;
  assign bus.busy     = (state_q != IDLE) || hold_valid_q;

  demux_route_1x4 #(.DW(DW)) u_route (
    .valid     (hold_valid_q),
    .data      (hold_data_q),
    .sel       (sel_q),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data)
  );

endmodule
